rx_frame_seq: RTL and testbench

//  Sequences the 802.11a receive datapath for one DATA frame. Counts coded bits into
//  per-symbol deinterleaver blocks, tracks decoded bits from the Viterbi stage and

---
 rtl/rx_frame_seq.sv | 182 ++++++++++++++++++
 tb/tb_rx_frame_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_seq.sv
// Receive-side sequencer for one 802.11a DATA frame: coded-bit block counting,
// decoded-bit phase tracking (SERVICE/PAYLOAD/TRAIL), seed recovery and end-of-frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; config is checked on the start pulse
// SERVICE | decoded SERVICE bits; first 7 feed the descrambler seed
// PAYLOAD | decoded bits are payload, qualified with out_valid
// TRAIL   | tail and pad bits, discarded until dbit reaches total
// DONE    | one-cycle ready pulse, then back to IDLE
module rx_frame_seq #(
    parameter int N_CBPS = 48,
    parameter int N_DBPS = 24,
    parameter int SERV   = 16,
    parameter int TAIL   = 6,
    parameter int CNT_W  = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] n_sym,
    input  logic [5:0] n_pad,
    input  logic       in_valid,
    input  logic       dec_valid,
    output logic       deint_wr_en,
    output logic       deint_blk_done,
    output logic       seed_load,
    output logic       out_valid,
    output logic       busy,
    output logic       ready,
    output logic       err
);

    localparam int CBIT_W = $clog2(N_CBPS);
    localparam logic [CNT_W-1:0]  N_DBPS_C = CNT_W'(N_DBPS);
    localparam logic [CNT_W-1:0]  SERV_C   = CNT_W'(SERV);
    localparam logic [CNT_W-1:0]  TAIL_C   = CNT_W'(TAIL);
    localparam logic [CNT_W-1:0]  SEED_C   = CNT_W'(7);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [CBIT_W-1:0] CBIT_LAST = CBIT_W'(N_CBPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SERVICE,
        PAYLOAD,
        TRAIL,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  pay_end_q;
    logic [7:0]        n_sym_q;
    logic [CNT_W-1:0]  dbit_q;
    logic [CBIT_W-1:0] cbit_q;
    logic [7:0]        sym_q;
    logic              blk_done_q;
    logic              err_q;

    logic [CNT_W-1:0] total_calc;
    logic [CNT_W-1:0] need_calc;
    logic             cfg_ok;
    logic             accept;
    logic             coded_take;
    logic             coded_stray;
    logic             err_d;

    // Frame length arithmetic at full counter width so small n_sym cannot wrap.
    assign total_calc = CNT_W'(n_sym) * N_DBPS_C;
    assign need_calc  = SERV_C + TAIL_C + CNT_W'(n_pad);
    assign cfg_ok     = (n_sym != 8'd0) && (total_calc >= need_calc);
    assign accept     = (state_q == IDLE) && start && cfg_ok;

    assign busy  = (state_q == SERVICE) || (state_q == PAYLOAD) || (state_q == TRAIL);
    assign ready = (state_q == DONE);

    assign deint_wr_en    = in_valid & busy;
    assign deint_blk_done = blk_done_q;
    assign seed_load      = (state_q == SERVICE) && dec_valid && (dbit_q < SEED_C);
    assign out_valid      = (state_q == PAYLOAD) && dec_valid;
    assign err            = err_q;

    assign coded_take  = in_valid && busy && (sym_q != n_sym_q);
    assign coded_stray = in_valid && !coded_take;

    always_comb begin
        err_d = 1'b0;
        if (start && (state_q != IDLE))
            err_d = 1'b1;
        if (start && (state_q == IDLE) && !cfg_ok)
            err_d = 1'b1;
        if (coded_stray)
            err_d = 1'b1;
    end

    // Phase boundaries are decided on the bit that completes the phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = SERVICE;
            end
            SERVICE: begin
                if (dec_valid && (dbit_q == SERV_C - ONE_C))
                    state_d = (pay_end_q == SERV_C) ? TRAIL : PAYLOAD;
            end
            PAYLOAD: begin
                if (dec_valid && (dbit_q == pay_end_q - ONE_C))
                    state_d = TRAIL;
            end
            TRAIL: begin
                if (dec_valid && (dbit_q == total_q - ONE_C))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            total_q   <= '0;
            pay_end_q <= '0;
            n_sym_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                total_q   <= total_calc;
                pay_end_q <= total_calc - TAIL_C - CNT_W'(n_pad);
                n_sym_q   <= n_sym;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            dbit_q <= '0;
        end else if (accept) begin
            dbit_q <= '0;
        end else if (dec_valid && busy) begin
            dbit_q <= dbit_q + ONE_C;
        end
    end

    // Coded side runs independently of the decoded phases.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cbit_q     <= '0;
            sym_q      <= '0;
            blk_done_q <= 1'b0;
        end else begin
            blk_done_q <= 1'b0;
            if (accept) begin
                cbit_q <= '0;
                sym_q  <= '0;
            end else if (coded_take) begin
                if (cbit_q == CBIT_LAST) begin
                    cbit_q     <= '0;
                    sym_q      <= sym_q + 8'd1;
                    blk_done_q <= 1'b1;
                end else begin
                    cbit_q <= cbit_q + CBIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_seq.sv
// Directed bench for rx_frame_seq: table of frame configs plus hand-written
// reset, stray-input and abort sequences.
module tb_rx_frame_seq;

    logic       Clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] n_sym;
    logic [5:0] n_pad;
    logic       in_valid;
    logic       dec_valid;
    logic       deint_wr_en;
    logic       deint_blk_done;
    logic       seed_load;
    logic       out_valid;
    logic       busy;
    logic       ready;
    logic       err;

    rx_frame_seq dut (
        .Clk            (Clk),
        .reset          (reset),
        .start          (start),
        .n_sym          (n_sym),
        .n_pad          (n_pad),
        .in_valid       (in_valid),
        .dec_valid      (dec_valid),
        .deint_wr_en    (deint_wr_en),
        .deint_blk_done (deint_blk_done),
        .seed_load      (seed_load),
        .out_valid      (out_valid),
        .busy           (busy),
        .ready          (ready),
        .err            (err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int n_sym;
        int n_pad;
        int cfg_err;
        int n_coded;
        int gap;
        int dec_off;
        int n_dec;
        int mid_start;
        int exp_blk;
        int exp_seed;
        int exp_out;
        int exp_first;
        int exp_run_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    int blk_cnt, seed_cnt, seed_last, out_cnt, out_first, out_last;
    int ready_cnt, ready_cyc, last_dec_cyc, err_cnt, busy_seen;
    int blk_pos[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int ns, input int np, input int exp_err);
        @(posedge Clk); #1;
        n_sym = 8'(ns);
        n_pad = 6'(np);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        chk("start_err", int'(err), exp_err);
        chk("start_busy", int'(busy), 1 - exp_err);
    endtask

    task automatic run(input int n_coded, input int gap, input int dec_off,
                       input int n_dec, input int mid_start);
        int coded_sent;
        int dec_sent;
        int ncyc;
        bit iv;
        bit dv;
        coded_sent = 0; dec_sent = 0;
        blk_cnt = 0; seed_cnt = 0; seed_last = -1; out_cnt = 0;
        out_first = -1; out_last = -1; ready_cnt = 0; ready_cyc = -1;
        last_dec_cyc = -1; err_cnt = 0; busy_seen = 0;
        for (int k = 0; k < 4; k++) blk_pos[k] = -1;
        ncyc = n_coded * gap;
        if (dec_off + n_dec > ncyc) ncyc = dec_off + n_dec;
        ncyc = ncyc + 3;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge Clk); #1;
            iv = (coded_sent < n_coded) && ((i % gap) == 0);
            dv = (i >= dec_off) && (dec_sent < n_dec);
            in_valid  = iv;
            dec_valid = dv;
            start     = (i == mid_start);
            if (i == mid_start) begin
                n_sym = 8'd1;
                n_pad = 6'd0;
            end
            @(negedge Clk);
            if (deint_blk_done) begin
                if (blk_cnt < 4) blk_pos[blk_cnt] = coded_sent;
                blk_cnt++;
            end
            if (seed_load) begin
                seed_cnt++;
                seed_last = dec_sent;
            end
            if (out_valid) begin
                if (out_cnt == 0) out_first = dec_sent;
                out_last = dec_sent;
                out_cnt++;
            end
            if (ready) begin
                ready_cnt++;
                ready_cyc = i;
            end
            if (err) err_cnt++;
            if (busy) busy_seen = 1;
            if (iv) coded_sent++;
            if (dv) begin
                dec_sent++;
                last_dec_cyc = i;
            end
        end
        in_valid  = 1'b0;
        dec_valid = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        //           ns pad cerr coded gap off  ndec mid  blk seed out first rerr
        vecs[0] = '{2,  2,  0,   96,   1,  100, 48,  -1,  2,  7,   24, 16,   0};
        vecs[1] = '{1,  2,  0,   48,   1,  50,  24,  -1,  1,  7,   0,  -1,   0};
        vecs[2] = '{1,  3,  1,   0,    1,  0,   0,   -1,  0,  0,   0,  -1,   0};
        vecs[3] = '{3,  0,  0,   144,  3,  440, 72,  -1,  3,  7,   50, 16,   0};
        vecs[4] = '{0,  0,  1,   0,    1,  0,   0,   -1,  0,  0,   0,  -1,   0};
        vecs[5] = '{2,  63, 1,   0,    1,  0,   0,   -1,  0,  0,   0,  -1,   0};
        vecs[6] = '{4,  63, 0,   192,  1,  200, 96,  -1,  4,  7,   11, 16,   0};
        vecs[7] = '{2,  2,  0,   96,   1,  100, 48,  20,  2,  7,   24, 16,   1};
        vecs[8] = '{2,  2,  0,   97,   1,  100, 48,  -1,  2,  7,   24, 16,   1};
        vecs[9] = '{1,  0,  0,   48,   1,  50,  24,  -1,  1,  7,   2,  16,   0};

        reset = 1'b1; start = 1'b0; n_sym = 8'd0; n_pad = 6'd0;
        in_valid = 1'b1; dec_valid = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_wr_en", int'(deint_wr_en), 0);
        chk("rst_blk_done", int'(deint_blk_done), 0);
        chk("rst_seed", int'(seed_load), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_err", int'(err), 0);
        in_valid = 1'b0; dec_valid = 1'b0;
        reset = 1'b0;

        // stray coded bit while idle
        @(posedge Clk); #1;
        in_valid = 1'b1;
        @(negedge Clk);
        chk("idle_wr_en", int'(deint_wr_en), 0);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(negedge Clk);
        chk("idle_in_err", int'(err), 1);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("idle_err_pulse", int'(err), 0);

        // abort mid-frame with reset after 30 decoded bits
        do_start(2, 2, 0);
        run(0, 1, 0, 30, -1);
        chk("abort_out_cnt", out_cnt, 14);
        chk("abort_no_ready", ready_cnt, 0);
        @(posedge Clk); #1;
        dec_valid = 1'b1;
        @(negedge Clk);
        chk("abort_pre_out", int'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ready), 0);
        chk("abort_seed", int'(seed_load), 0);
        chk("abort_err", int'(err), 0);
        dec_valid = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort_held_ready", int'(ready), 0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            do_start(vecs[v].n_sym, vecs[v].n_pad, vecs[v].cfg_err);
            run(vecs[v].n_coded, vecs[v].gap, vecs[v].dec_off,
                vecs[v].n_dec, vecs[v].mid_start);
            chk($sformatf("v%0d_blk", v), blk_cnt, vecs[v].exp_blk);
            for (int k = 0; k < vecs[v].exp_blk && k < 4; k++)
                chk($sformatf("v%0d_blk_pos%0d", v, k), blk_pos[k], 48 * (k + 1));
            chk($sformatf("v%0d_seed", v), seed_cnt, vecs[v].exp_seed);
            if (vecs[v].exp_seed > 0)
                chk($sformatf("v%0d_seed_last", v), seed_last, 6);
            chk($sformatf("v%0d_out", v), out_cnt, vecs[v].exp_out);
            if (vecs[v].exp_out > 0) begin
                chk($sformatf("v%0d_out_first", v), out_first, vecs[v].exp_first);
                chk($sformatf("v%0d_out_last", v), out_last,
                    vecs[v].exp_first + vecs[v].exp_out - 1);
            end
            chk($sformatf("v%0d_ready", v), ready_cnt, 1 - vecs[v].cfg_err);
            if (vecs[v].cfg_err == 0)
                chk($sformatf("v%0d_ready_lat", v), ready_cyc - last_dec_cyc, 1);
            else
                chk($sformatf("v%0d_busy_seen", v), busy_seen, 0);
            chk($sformatf("v%0d_run_err", v), err_cnt, vecs[v].exp_run_err);
            chk($sformatf("v%0d_end_busy", v), int'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
